// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter that shares one 8:1 mux among eight requesters. One
// requester is granted at a time, and each grant is capped at MAX_HOLD
// consecutive cycles. When a grant is released, the next winner is granted on
// the same edge, so a handover adds no idle cycle.
//
// Parameters
//   MAX_HOLD  : maximum consecutive cycles of one grant (1..255)
// Ports
//   clk       : single clock; all state changes on the rising edge
//   rst       : synchronous, active-high reset
//   req[7:0]  : level request per requester (bit i -> mux in[i])
//   gnt[7:0]  : registered one-hot grant, zero when idle
//   gnt_valid : registered, equals |gnt
//   sel[2:0]  : granted index for the mux select; holds its value when idle
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic [2:0] sel
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  // Round-robin pick: scan r upward from p (mod 8) and return {found, index}.
  // The loop runs from the farthest offset down, so the nearest set bit is
  // the last assignment and therefore the one returned.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [0:0] state_r, state_s;
  logic [2:0] ptr_r, ptr_s;
  logic [7:0] hold_cnt_r, hold_cnt_s;
  logic [7:0] gnt_r, gnt_s;
  logic [2:0] sel_r, sel_s;
  logic       gnt_valid_r, gnt_valid_s;

  logic       release_s;
  logic [2:0] scan_ptr_s;
  logic [3:0] pick_s;

  // Release detection and the arbitration input. On a release the scan
  // starts just past the releasing requester, which makes it the lowest
  // priority while it stays eligible.
  always_comb begin
    release_s  = 1'b0;
    scan_ptr_s = ptr_r;
    if (state_r == BUSY) begin
      release_s = (req[sel_r] == 1'b0) || (hold_cnt_r == MAX_HOLD_C);
    end else begin
      release_s = 1'b0;
    end
    if (release_s) begin
      scan_ptr_s = sel_r + 3'd1;
    end else begin
      scan_ptr_s = ptr_r;
    end
    pick_s = rr_pick(req, scan_ptr_s);
  end

  // Next-state logic for the IDLE/BUSY controller and the output registers.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    hold_cnt_s  = hold_cnt_r;
    gnt_s       = gnt_r;
    sel_s       = sel_r;
    gnt_valid_s = gnt_valid_r;
    case (state_r)
      IDLE: begin
        if (pick_s[3]) begin
          state_s     = BUSY;
          sel_s       = pick_s[2:0];
          gnt_s       = 8'd1 << pick_s[2:0];
          gnt_valid_s = 1'b1;
          hold_cnt_s  = 8'd1;
        end else begin
          gnt_s       = 8'd0;
          gnt_valid_s = 1'b0;
        end
      end
      BUSY: begin
        if (!release_s) begin
          hold_cnt_s = hold_cnt_r + 8'd1;
        end else if (pick_s[3]) begin
          // Back-to-back handover; a sole requester at the cap lands here
          // and is re-granted with an unchanged gnt.
          ptr_s       = scan_ptr_s;
          sel_s       = pick_s[2:0];
          gnt_s       = 8'd1 << pick_s[2:0];
          gnt_valid_s = 1'b1;
          hold_cnt_s  = 8'd1;
        end else begin
          // Nobody left: drop the grant but keep sel at its last value.
          ptr_s       = scan_ptr_s;
          state_s     = IDLE;
          gnt_s       = 8'd0;
          gnt_valid_s = 1'b0;
          hold_cnt_s  = 8'd0;
        end
      end
      default: begin
        state_s     = IDLE;
        gnt_s       = 8'd0;
        gnt_valid_s = 1'b0;
        hold_cnt_s  = 8'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= 3'd0;
      hold_cnt_r  <= 8'd0;
      gnt_r       <= 8'd0;
      sel_r       <= 3'd0;
      gnt_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      hold_cnt_r  <= hold_cnt_s;
      gnt_r       <= gnt_s;
      sel_r       <= sel_s;
      gnt_valid_r <= gnt_valid_s;
    end
  end

  assign gnt       = gnt_r;
  assign sel       = sel_r;
  assign gnt_valid = gnt_valid_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
// Directed, table-driven bench for mux_rr_arbiter with MAX_HOLD = 4. Each row
// holds the inputs driven before a rising edge and the outputs expected just
// after it. A short hand-written sequence follows the table.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] sel;

  int n_cmp;
  int n_err;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
  } vec_t;

  vec_t tbl [0:99];
  int   n_vec;

  mux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .sel       (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [7:0] q, input logic [7:0] g,
                     input logic [2:0] s, input logic v);
    tbl[n_vec].rst   = r;
    tbl[n_vec].req   = q;
    tbl[n_vec].gnt   = g;
    tbl[n_vec].sel   = s;
    tbl[n_vec].valid = v;
    n_vec++;
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %02h, expected %02h", name, idx, act, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_vec = 0;
    rst   = 1'b1;
    req   = 8'h00;

    // Reset held two cycles with every request asserted.
    add(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0);
    add(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0);
    // Full contention: 0..7 in order, four cycles each, then wrap to 0.
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        add(1'b0, 8'hFF, 8'h01 << k, 3'(k), 1'b1);
      end
    end
    add(1'b0, 8'hFF, 8'h01, 3'd0, 1'b1);
    // Idle gap: grant drops, sel holds 0.
    add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    // Single requester 5 for 10 cycles, re-granted at each cap without a glitch.
    for (int c = 0; c < 10; c++) begin
      add(1'b0, 8'h20, 8'h20, 3'd5, 1'b1);
    end
    // Drop to idle; sel keeps 5.
    add(1'b0, 8'h00, 8'h00, 3'd5, 1'b0);
    // Grant to 6 (ptr becomes 7 on release), then req=05 -> 0 first, then 2.
    add(1'b0, 8'h40, 8'h40, 3'd6, 1'b1);
    for (int c = 0; c < 4; c++) begin
      add(1'b0, 8'h05, 8'h01, 3'd0, 1'b1);
    end
    add(1'b0, 8'h05, 8'h04, 3'd2, 1'b1);
    // Early release: 2 keeps its grant one more cycle, then drops while 6 waits.
    add(1'b0, 8'h44, 8'h04, 3'd2, 1'b1);
    add(1'b0, 8'h40, 8'h40, 3'd6, 1'b1);
    // The hold restarted at 1, so 6 keeps the grant for three more cycles.
    for (int c = 0; c < 3; c++) begin
      add(1'b0, 8'hC0, 8'h40, 3'd6, 1'b1);
    end
    add(1'b0, 8'hC0, 8'h80, 3'd7, 1'b1);
    // Mid-grant reset clears outputs; afterwards the scan starts from 0 again.
    add(1'b1, 8'hC0, 8'h00, 3'd0, 1'b0);
    add(1'b0, 8'hC0, 8'h40, 3'd6, 1'b1);

    for (int i = 0; i < n_vec; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      req = tbl[i].req;
      @(posedge clk);
      #1;
      check("gnt", i, gnt, tbl[i].gnt);
      check("sel", i, {5'd0, sel}, {5'd0, tbl[i].sel});
      check("gnt_valid", i, {7'd0, gnt_valid}, {7'd0, tbl[i].valid});
    end

    // Hand-written: no combinational path from req to the outputs.
    @(negedge clk);
    req = 8'h00;
    @(posedge clk);
    #1;
    check("drop_gnt", 200, gnt, 8'h00);
    check("drop_sel", 200, {5'd0, sel}, 8'd6);
    @(negedge clk);
    req = 8'h08;
    #1;
    check("comb_gnt", 201, gnt, 8'h00);
    check("comb_sel", 201, {5'd0, sel}, 8'd6);
    @(posedge clk);
    #1;
    check("latency_gnt", 202, gnt, 8'h08);
    check("latency_sel", 202, {5'd0, sel}, 8'd3);
    check("latency_valid", 202, {7'd0, gnt_valid}, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
